nf10_ipif_bank_ctrl: RTL and testbench



---
 rtl/nf10_ipif_bank_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nf10_ipif_bank_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_ipif_bank_ctrl.sv
// IPIF-to-register-bank access controller: decodes one bank per access, issues a one-cycle
// request, waits for the bank ack with timeout. Optional stats via NF10_IPIF_BANK_STATS_EN.
module nf10_ipif_bank_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_BANK_SEL_BITS    = 2,
    parameter int C_BANK_ADDR_BITS   = 4,
    parameter int C_TIMEOUT          = 64
) (
    input  logic                                                  S_AXI_ACLK,
    input  logic                                                  S_AXI_ARESET,
    input  logic                                                  Bus2IP_CS,
    input  logic                                                  Bus2IP_RNW,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                         Bus2IP_Addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                         Bus2IP_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                       Bus2IP_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                         IP2Bus_Data,
    output logic                                                  IP2Bus_RdAck,
    output logic                                                  IP2Bus_WrAck,
    output logic                                                  IP2Bus_Error,
    output logic [(2**C_BANK_SEL_BITS)-1:0]                       bank_req,
    output logic                                                  bank_rnw,
    output logic [C_BANK_ADDR_BITS-1:0]                           bank_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                         bank_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]                       bank_be,
    input  logic [(2**C_BANK_SEL_BITS)-1:0]                       bank_ack,
    input  logic [(2**C_BANK_SEL_BITS)*C_S_AXI_DATA_WIDTH-1:0]    bank_rdata
`ifdef NF10_IPIF_BANK_STATS_EN
    ,
    output logic [15:0]                                           err_count,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]                         last_err_addr
`endif
);

    localparam int NUM_BANKS = 2**C_BANK_SEL_BITS;
    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int BEW       = C_S_AXI_DATA_WIDTH/8;
    localparam int SEL_LSB   = C_BANK_ADDR_BITS + 2;
    localparam int RANGE_LSB = SEL_LSB + C_BANK_SEL_BITS;
    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} state_t;

    state_t                      state_q, state_d;
    logic                        rnw_q, rnw_d;
    logic [C_BANK_ADDR_BITS-1:0] off_q, off_d;
    logic [DW-1:0]               wdata_q, wdata_d;
    logic [BEW-1:0]              be_q, be_d;
    logic [C_BANK_SEL_BITS-1:0]  sel_q, sel_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [DW-1:0]               rdata_q, rdata_d;
    logic                        err_q, err_d;

    // Bits between the bank select field and bit 16 must be clear; higher bits belong to the BAR.
    function automatic logic addr_in_range(input logic [AW-1:0] a);
        addr_in_range = 1'b1;
        for (int i = RANGE_LSB; i < 16 && i < AW; i++) begin
            if (a[i]) addr_in_range = 1'b0;
        end
    endfunction

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q <= IDLE;
            rnw_q   <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnw_q   <= rnw_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (Bus2IP_CS) begin
                    rnw_d   = Bus2IP_RNW;
                    off_d   = Bus2IP_Addr[2 +: C_BANK_ADDR_BITS];
                    wdata_d = Bus2IP_Data;
                    be_d    = Bus2IP_BE;
                    sel_d   = Bus2IP_Addr[SEL_LSB +: C_BANK_SEL_BITS];
                    if (!addr_in_range(Bus2IP_Addr)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = Bus2IP_CS ? WAIT : IDLE;
            end
            WAIT: begin
                // An abort takes priority; ack beats a coincident timeout.
                if (!Bus2IP_CS) begin
                    state_d = IDLE;
                end else if (bank_ack[sel_q]) begin
                    if (rnw_q) rdata_d = bank_rdata[int'(sel_q)*DW +: DW];
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    if (rnw_q) rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: state_d = HOLD;
            HOLD: if (!Bus2IP_CS) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_req[i] = (state_q == ISSUE) && (sel_q == i[C_BANK_SEL_BITS-1:0]);
        end
    end

    assign IP2Bus_RdAck = (state_q == RESP) && rnw_q;
    assign IP2Bus_WrAck = (state_q == RESP) && !rnw_q;
    assign IP2Bus_Data  = rdata_q;
    assign IP2Bus_Error = err_q;
    assign bank_rnw     = rnw_q;
    assign bank_addr    = off_q;
    assign bank_wdata   = wdata_q;
    assign bank_be      = be_q;

`ifdef NF10_IPIF_BANK_STATS_EN
    logic [15:0]   err_cnt_q;
    logic [AW-1:0] last_err_addr_q;

    // CS is still held in RESP, so the live address is the faulting one.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            err_cnt_q       <= '0;
            last_err_addr_q <= '0;
        end else if (state_q == RESP && err_q) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            last_err_addr_q <= Bus2IP_Addr;
        end
    end

    assign err_count     = err_cnt_q;
    assign last_err_addr = last_err_addr_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^Bus2IP_Addr;
`endif

endmodule

// File: tb/tb_nf10_ipif_bank_ctrl.sv
// Scoreboard bench for nf10_ipif_bank_ctrl: directed plus randomized accesses against a
// transaction-level model; a negedge monitor checks acks, requests and held outputs.
module tb_nf10_ipif_bank_ctrl;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cs;
    logic         rnw_in;
    logic [31:0]  addr_in;
    logic [31:0]  wdata_in;
    logic [3:0]   be_in;
    logic [31:0]  ip_data;
    logic         rdack;
    logic         wrack;
    logic         ip_err;
    logic [3:0]   bank_req;
    logic         bank_rnw;
    logic [3:0]   bank_addr;
    logic [31:0]  bank_wdata;
    logic [3:0]   bank_be;
    logic [3:0]   bank_ack;
    logic [127:0] bank_rdata;
`ifdef NF10_IPIF_BANK_STATS_EN
    logic [15:0]  err_count;
    logic [31:0]  last_err_addr;
`endif

    nf10_ipif_bank_ctrl #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_BANK_SEL_BITS(2),
        .C_BANK_ADDR_BITS(4),
        .C_TIMEOUT(TMO)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .Bus2IP_CS(cs),
        .Bus2IP_RNW(rnw_in),
        .Bus2IP_Addr(addr_in),
        .Bus2IP_Data(wdata_in),
        .Bus2IP_BE(be_in),
        .IP2Bus_Data(ip_data),
        .IP2Bus_RdAck(rdack),
        .IP2Bus_WrAck(wrack),
        .IP2Bus_Error(ip_err),
        .bank_req(bank_req),
        .bank_rnw(bank_rnw),
        .bank_addr(bank_addr),
        .bank_wdata(bank_wdata),
        .bank_be(bank_be),
        .bank_ack(bank_ack),
        .bank_rdata(bank_rdata)
`ifdef NF10_IPIF_BANK_STATS_EN
        ,
        .err_count(err_count),
        .last_err_addr(last_err_addr)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        rnw;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  addr;
        logic        rnw;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
    } req_t;

    resp_t resp_q[$];
    req_t  req_q[$];

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    logic [31:0] m_data     = '0;
    int          m_err_cnt  = 0;
    logic [31:0] m_last_err = '0;

    logic [31:0] hold_data = '0;
    logic        hold_err  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            hold_data = '0;
            hold_err  = 1'b0;
        end else begin
            if (rdack || wrack) begin
                checks++;
                if (resp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: got rd=%0b wr=%0b at cyc=%0d, want no ack", rdack, wrack, cyc);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    if (rdack !== e.rnw || wrack !== !e.rnw || ip_data !== e.data ||
                        ip_err !== e.err || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL resp: got rd=%0b wr=%0b data=%h err=%0b cyc=%0d, want rnw=%0b data=%h err=%0b cyc=%0d",
                                 rdack, wrack, ip_data, ip_err, cyc, e.rnw, e.data, e.err, e.cyc);
                    end
                    hold_data = e.data;
                    hold_err  = e.err;
                end
            end else begin
                checks++;
                if (ip_data !== hold_data || ip_err !== hold_err) begin
                    failures++;
                    $display("FAIL hold: got data=%h err=%0b at cyc=%0d, want data=%h err=%0b",
                             ip_data, ip_err, cyc, hold_data, hold_err);
                end
            end
            if (bank_req != 4'b0) begin
                checks++;
                if (req_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req: got req=%b at cyc=%0d, want none", bank_req, cyc);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    if (bank_req !== r.req || bank_addr !== r.addr || bank_rnw !== r.rnw ||
                        bank_wdata !== r.wdata || bank_be !== r.be || cyc != r.cyc) begin
                        failures++;
                        $display("FAIL req: got req=%b addr=%0d rnw=%0b wdata=%h be=%h cyc=%0d, want req=%b addr=%0d rnw=%0b wdata=%h be=%h cyc=%0d",
                                 bank_req, bank_addr, bank_rnw, bank_wdata, bank_be, cyc,
                                 r.req, r.addr, r.rnw, r.wdata, r.be, r.cyc);
                    end
                end
            end
        end
    end

    task automatic check_stats(input string name);
`ifdef NF10_IPIF_BANK_STATS_EN
        checks++;
        if (err_count !== 16'(m_err_cnt) || last_err_addr !== m_last_err) begin
            failures++;
            $display("FAIL %s: got err_count=%0d last_err_addr=%h, want %0d %h",
                     name, err_count, last_err_addr, m_err_cnt, m_last_err);
        end
`else
        if (name.len() < 0) checks++;
`endif
    endtask

    task automatic drive_rdata_noise();
        for (int b = 0; b < 4; b++) bank_rdata[b*32 +: 32] = $urandom;
    endtask

    // d: WAIT-cycle index at which the bank acks (-1 none); a: WAIT-cycle index where CS drops (-1 none)
    task automatic access(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int d, input int a, input int hold,
                          input bit stray);
        logic [31:0] rval;
        logic        in_range;
        logic [1:0]  sel;
        logic [3:0]  off;
        int          k;
        int          rt;
        int          last;
        resp_t       e;
        req_t        r;
        rval     = $urandom;
        in_range = (addr[15:8] == 8'h00);
        sel      = addr[7:6];
        off      = addr[5:2];
        @(posedge clk); #1;
        cs = 1'b1; rnw_in = rnw; addr_in = addr; wdata_in = wdata; be_in = be;
        bank_ack = '0;
        drive_rdata_noise();
        k = cyc;
        if (!in_range)                 rt = 1;
        else if (d >= 0 && d <= TMO-1) rt = 3 + d;
        else                           rt = 2 + TMO;
        if (a < 0) begin
            e.rnw = rnw;
            e.cyc = k + rt;
            if (!in_range) begin
                e.err = 1'b1; e.data = '0;
            end else if (d >= 0 && d <= TMO-1) begin
                e.err = 1'b0; e.data = rnw ? rval : m_data;
            end else begin
                e.err = 1'b1; e.data = rnw ? 32'h0 : m_data;
            end
            m_data = e.data;
            if (e.err) begin
                if (m_err_cnt < 65535) m_err_cnt++;
                m_last_err = addr;
            end
            resp_q.push_back(e);
        end
        if (in_range) begin
            r.req = 4'b0001 << sel; r.addr = off; r.rnw = rnw;
            r.wdata = wdata; r.be = be; r.cyc = k + 1;
            req_q.push_back(r);
        end
        last = (a >= 0) ? 3 + a : rt + hold + 1;
        for (int t = 1; t <= last; t++) begin
            @(posedge clk); #1;
            bank_ack = '0;
            drive_rdata_noise();
            if (in_range && d >= 0 && t == 2 + d) begin
                bank_ack[sel] = 1'b1;
                bank_rdata[int'(sel)*32 +: 32] = rval;
            end
            if (stray && t == 2) bank_ack[sel ^ 2'd3] = 1'b1;
            if (a >= 0 && t >= 2 + a) cs = 1'b0;
            if (a < 0 && t == last) cs = 1'b0;
        end
        check_stats("stats");
    endtask

    task automatic reset_mid_wait();
        int k;
        req_t r;
        @(posedge clk); #1;
        cs = 1'b1; rnw_in = 1'b1; addr_in = 32'h80; wdata_in = 32'hA5A5A5A5; be_in = 4'h3;
        bank_ack = '0;
        k = cyc;
        r.req = 4'b0100; r.addr = 4'd0; r.rnw = 1'b1; r.wdata = 32'hA5A5A5A5; r.be = 4'h3; r.cyc = k + 1;
        req_q.push_back(r);
        for (int t = 1; t <= 3; t++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ip_data !== '0 || rdack !== 1'b0 || wrack !== 1'b0 || ip_err !== 1'b0 ||
            bank_req !== '0 || bank_rnw !== 1'b0 || bank_addr !== '0 ||
            bank_wdata !== '0 || bank_be !== '0) begin
            failures++;
            $display("FAIL reset_mid: got data=%h rd=%0b wr=%0b err=%0b req=%b rnw=%0b addr=%0d wdata=%h be=%h, want all 0",
                     ip_data, rdack, wrack, ip_err, bank_req, bank_rnw, bank_addr, bank_wdata, bank_be);
        end
        cs = 1'b0;
        m_data = '0; m_err_cnt = 0; m_last_err = '0;
        check_stats("stats_reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no end of test by %0t, want finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rr;
        logic [31:0] ra;
        int          rd, ab, hd;
        bit          st;
        rst = 1'b1; cs = 1'b0; rnw_in = 1'b0; addr_in = '0; wdata_in = '0; be_in = '0;
        bank_ack = '0; bank_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ip_data !== '0 || rdack !== 1'b0 || wrack !== 1'b0 || ip_err !== 1'b0 ||
            bank_req !== '0 || bank_rnw !== 1'b0 || bank_addr !== '0 ||
            bank_wdata !== '0 || bank_be !== '0) begin
            failures++;
            $display("FAIL reset_state: got data=%h rd=%0b wr=%0b err=%0b req=%b, want all 0",
                     ip_data, rdack, wrack, ip_err, bank_req);
        end
        check_stats("stats_init");
        rst = 1'b0;

        access(1'b1, 32'h4C, 32'h0, 4'hF, 0, -1, 0, 1'b0);
        access(1'b0, 32'h08, 32'hCAFEF00D, 4'hF, 1, -1, 0, 1'b0);
        access(1'b1, 32'h80, 32'h0, 4'hF, -1, -1, 0, 1'b0);
        access(1'b1, 32'h1000, 32'h0, 4'hF, -1, -1, 0, 1'b0);
        access(1'b1, 32'h04, 32'h0, 4'hF, 2, -1, 0, 1'b1);
        access(1'b1, 32'h44, 32'h0, 4'hF, 2, 1, 0, 1'b0);
        access(1'b1, 32'h44, 32'h0, 4'hF, 0, -1, 0, 1'b0);
        reset_mid_wait();
        access(1'b1, 32'h0C, 32'h0, 4'hF, 1, -1, 0, 1'b0);
        access(1'b1, 32'hC8, 32'h0, 4'hF, 1, -1, 4, 1'b0);
        access(1'b0, 32'hC8, 32'h11223344, 4'h5, 0, -1, 0, 1'b0);
        access(1'b1, 32'h40, 32'h0, 4'hF, TMO-1, -1, 0, 1'b0);
        access(1'b0, 32'h84, 32'h55AA55AA, 4'hC, -1, -1, 1, 1'b0);
        access(1'b0, 32'h0001_0100, 32'h99, 4'h1, -1, -1, 0, 1'b0);
        access(1'b1, 32'hFFFF_0013, 32'h0, 4'hF, 0, -1, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rr = 1'($urandom_range(0, 1));
            ra = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(8, 15));
            rd = int'($urandom_range(0, 6)) - 1;
            ab = -1;
            if (ra[15:8] == 8'h00 && $urandom_range(0, 5) == 0) begin
                ab = int'($urandom_range(0, TMO-1));
                rd = ab + 1;
            end
            hd = int'($urandom_range(0, 2));
            st = ($urandom_range(0, 3) == 0);
            access(rr, ra, $urandom, 4'($urandom_range(0, 15)), rd, ab, hd, st);
        end

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (resp_q.size() != 0) begin
            failures++;
            $display("FAIL resp_drain: got %0d pending acks, want 0", resp_q.size());
        end
        checks++;
        if (req_q.size() != 0) begin
            failures++;
            $display("FAIL req_drain: got %0d pending requests, want 0", req_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
